sel_reg_scan: RTL



---
 rtl/sel_reg_pkg.sv | 16 +
 rtl/scan_ctr.sv | 61 ++++++
 rtl/sel_reg_scan.sv | 128 ++++++++++++
 3 files changed

// File: rtl/sel_reg_pkg.sv
// Shared mode encoding and state type for the selecting register with scan.
package sel_reg_pkg;

  localparam logic [1:0] MODE_HOLD   = 2'b00;
  localparam logic [1:0] MODE_MANUAL = 2'b01;
  localparam logic [1:0] MODE_SCAN   = 2'b10;
  localparam logic [1:0] MODE_CLEAR  = 2'b11;

  typedef enum logic [1:0] {
    ST_HOLD   = 2'b00,
    ST_MANUAL = 2'b01,
    ST_SCAN   = 2'b10,
    ST_CLEAR  = 2'b11
  } state_e;

endpackage

// File: rtl/scan_ctr.sv
// Dwell counter and round-robin channel pointer for SCAN mode.
// adv_o fires on cycles where the current channel's dwell has expired;
// the pointer names the channel to load on that advance.
module scan_ctr #(
  parameter int NCH     = 4,
  parameter int DWELL_W = 8,
  parameter int SELW    = $clog2(NCH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,   // first SCAN cycle: channel 0 loaded by top
  input  logic               run_i,     // subsequent SCAN cycles
  input  logic               clr_i,
  input  logic [DWELL_W-1:0] dwell_i,
  output logic               adv_o,
  output logic [SELW-1:0]    ptr_o,
  output logic               wrap_o
);

  localparam logic [SELW-1:0] PTR_LAST = SELW'(NCH - 1);

  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [SELW-1:0]    ptr_q, ptr_d;

  assign adv_o  = run_i && (cnt_q == '0);
  assign ptr_o  = ptr_q;
  // Advancing onto channel 0 can only follow channel NCH-1.
  assign wrap_o = adv_o && (ptr_q == '0);

  // Next-state for counter and pointer; frozen unless scanning or clearing.
  always_comb begin
    cnt_d = cnt_q;
    ptr_d = ptr_q;
    if (clr_i) begin
      cnt_d = '0;
      ptr_d = '0;
    end else if (start_i) begin
      cnt_d = dwell_i;
      ptr_d = SELW'(1);
    end else if (run_i) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - DWELL_W'(1);
      end else begin
        cnt_d = dwell_i;
        ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + SELW'(1);
      end
    end
  end

  // Counter/pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      ptr_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/sel_reg_scan.sv
// Registers one of NCH channels onto q, by manual select or autonomous
// round-robin scan. All outputs are registered.
module sel_reg_scan
  import sel_reg_pkg::*;
#(
  parameter  int WIDTH   = 4,
  parameter  int NCH     = 4,
  parameter  int DWELL_W = 8,
  localparam int SELW    = $clog2(NCH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             mode,
  input  logic [SELW-1:0]        sel,
  input  logic                   load_en,
  input  logic [DWELL_W-1:0]     dwell,
  input  logic [NCH*WIDTH-1:0]   din,
  output logic [WIDTH-1:0]       q,
  output logic [SELW-1:0]        q_ch,
  output logic                   q_valid,
  output logic                   scan_wrap
);

  localparam logic [SELW:0] NCH_L = (SELW+1)'(NCH);

  state_e state_q, state_d;

  logic [NCH-1:0][WIDTH-1:0] din_a;
  logic [WIDTH-1:0] q_q, q_d;
  logic [SELW-1:0]  ch_q, ch_d;
  logic             vld_q, vld_d;
  logic             wrap_q, wrap_d;

  logic             scan_start, scan_run, clr, sel_ok;
  logic             adv, ctr_wrap;
  logic [SELW-1:0]  ptr;

  assign din_a = din;
  // Out-of-range sel (non-power-of-2 NCH) must never index the mux.
  assign sel_ok = ({1'b0, sel} < NCH_L);

  assign scan_start = (state_d == ST_SCAN) && (state_q != ST_SCAN);
  assign scan_run   = (state_d == ST_SCAN) && (state_q == ST_SCAN);
  assign clr        = (state_d == ST_CLEAR);

  scan_ctr #(.NCH(NCH), .DWELL_W(DWELL_W), .SELW(SELW)) u_scan_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (scan_start),
    .run_i   (scan_run),
    .clr_i   (clr),
    .dwell_i (dwell),
    .adv_o   (adv),
    .ptr_o   (ptr),
    .wrap_o  (ctr_wrap)
  );

  // Next state is a direct decode of mode; state_q remembers the last one
  // so SCAN entry can be detected.
  always_comb begin
    state_d = ST_HOLD;
    case (mode)
      MODE_HOLD:   state_d = ST_HOLD;
      MODE_MANUAL: state_d = ST_MANUAL;
      MODE_SCAN:   state_d = ST_SCAN;
      MODE_CLEAR:  state_d = ST_CLEAR;
      default:     state_d = ST_HOLD;
    endcase
  end

  // Output register next-state per mode.
  always_comb begin
    q_d    = q_q;
    ch_d   = ch_q;
    vld_d  = vld_q;
    wrap_d = 1'b0;
    case (state_d)
      ST_MANUAL: begin
        if (load_en && sel_ok) begin
          q_d   = din_a[sel];
          ch_d  = sel;
          vld_d = 1'b1;
        end
      end
      ST_SCAN: begin
        if (scan_start) begin
          q_d   = din_a[0];
          ch_d  = '0;
          vld_d = 1'b1;
        end else if (adv) begin
          q_d    = din_a[ptr];
          ch_d   = ptr;
          vld_d  = 1'b1;
          wrap_d = ctr_wrap;
        end
      end
      ST_CLEAR: begin
        q_d   = '0;
        ch_d  = '0;
        vld_d = 1'b0;
      end
      default: ;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_HOLD;
      q_q     <= '0;
      ch_q    <= '0;
      vld_q   <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      ch_q    <= ch_d;
      vld_q   <= vld_d;
      wrap_q  <= wrap_d;
    end
  end

  assign q         = q_q;
  assign q_ch      = ch_q;
  assign q_valid   = vld_q;
  assign scan_wrap = wrap_q;

endmodule
